// File: rtl/hwag_ign_sched.sv
`default_nettype none
// ============================================================================
// Module   : hwag_ign_sched
// Brief    : Angle-driven ignition channel scheduler with atomic set/reset
//            angle commit at the 720-degree wrap.
// Revision : 1.0
// ============================================================================
module hwag_ign_sched #(
  parameter int CH        = 4,
  parameter int AW        = 24,
  parameter int ANGLE_TOP = 7679
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hwag_start,
  input  logic [AW-1:0]         angle,
  input  logic                  wr_en,
  input  logic [$clog2(CH)-1:0] wr_addr,
  input  logic                  wr_sel,
  input  logic [AW-1:0]         wr_data,
  output logic                  wr_err,
  input  logic                  commit_req,
  output logic                  commit_pending,
  output logic                  commit_ack,
  output logic [CH-1:0]         ch_out
);

  localparam int            C_AIW       = $clog2(CH);
  localparam logic [AW-1:0] C_ANGLE_TOP = AW'(ANGLE_TOP);

  typedef enum logic [0:0] {
    CM_IDLE = 1'b0,
    CM_PEND = 1'b1
  } commit_state_t;

  typedef enum logic [0:0] {
    CH_OFF = 1'b0,
    CH_ON  = 1'b1
  } ch_state_t;

  logic [AW-1:0] r_angle_q;
  commit_state_t r_cm_state;
  logic          r_commit_pending;
  logic          r_commit_ack;
  logic          r_wr_err;
  logic          w_wrap;
  logic          w_xfer;
  logic          w_wr_ok;

  assign w_wrap  = hwag_start & (r_angle_q == C_ANGLE_TOP) & (angle == '0);
  assign w_xfer  = (r_cm_state == CM_PEND) & (w_wrap | ~hwag_start);
  assign w_wr_ok = (wr_data <= C_ANGLE_TOP) && (32'(wr_addr) < 32'(CH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_angle_q <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_angle_q <= angle;
      r_wr_err  <= wr_en & ~w_wr_ok;
    end
  end

  // Commit handshake; a request seen while pending is simply absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cm_state       <= CM_IDLE;
      r_commit_pending <= 1'b0;
      r_commit_ack     <= 1'b0;
    end else begin
      r_commit_ack <= 1'b0;
      unique case (r_cm_state)
        CM_IDLE: begin
          if (commit_req) begin
            r_cm_state       <= CM_PEND;
            r_commit_pending <= 1'b1;
          end
        end
        CM_PEND: begin
          if (w_xfer) begin
            r_cm_state       <= CM_IDLE;
            r_commit_pending <= 1'b0;
            r_commit_ack     <= 1'b1;
          end
        end
        default: begin
          r_cm_state       <= CM_IDLE;
          r_commit_pending <= 1'b0;
        end
      endcase
    end
  end

  assign wr_err         = r_wr_err;
  assign commit_pending = r_commit_pending;
  assign commit_ack     = r_commit_ack;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [AW-1:0] r_sh_set;
    logic [AW-1:0] r_sh_rst;
    logic [AW-1:0] r_act_set;
    logic [AW-1:0] r_act_rst;
    ch_state_t     r_state;
    logic          w_wr_here;
    logic          w_hit_set;
    logic          w_hit_rst;

    assign w_wr_here = wr_en & w_wr_ok & (wr_addr == C_AIW'(g));
    // Equal set/reset angles disable the channel entirely.
    assign w_hit_set = hwag_start & (angle == r_act_set) & (r_act_set != r_act_rst);
    assign w_hit_rst = hwag_start & (angle == r_act_rst);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sh_set <= '0;
        r_sh_rst <= '0;
      end else if (w_wr_here) begin
        if (wr_sel) r_sh_rst <= wr_data;
        else        r_sh_set <= wr_data;
      end
    end

    // Transfer samples the shadow before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_act_set <= '0;
        r_act_rst <= '0;
      end else if (w_xfer) begin
        r_act_set <= r_sh_set;
        r_act_rst <= r_sh_rst;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= CH_OFF;
      end else if (!hwag_start) begin
        r_state <= CH_OFF;
      end else begin
        unique case (r_state)
          CH_OFF:  if (w_hit_set && !w_hit_rst) r_state <= CH_ON;
          CH_ON:   if (w_hit_rst) r_state <= CH_OFF;
          default: r_state <= CH_OFF;
        endcase
      end
    end

    assign ch_out[g] = (r_state == CH_ON);
  end

endmodule
`default_nettype wire

// File: tb/tb_hwag_ign_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_ign_sched
// Brief    : Directed self-checking bench for hwag_ign_sched.
// Revision : 1.0
// ============================================================================
module tb_hwag_ign_sched;

  localparam int CH  = 4;
  localparam int AW  = 24;
  localparam int TOP = 7679;

  logic          clk = 1'b0;
  logic          rst;
  logic          hwag_start;
  logic [AW-1:0] angle;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic          wr_sel;
  logic [AW-1:0] wr_data;
  logic          wr_err;
  logic          commit_req;
  logic          commit_pending;
  logic          commit_ack;
  logic [CH-1:0] ch_out;

  int n_total = 0;
  int n_bad   = 0;

  int rise_cnt [CH];
  int fall_cnt [CH];
  int high_cnt [CH];
  int rise_ang [CH];
  int fall_ang [CH];
  int ack_cnt;
  int ack_ang;
  int err_cnt;

  hwag_ign_sched #(.CH(CH), .AW(AW), .ANGLE_TOP(TOP)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .hwag_start     (hwag_start),
    .angle          (angle),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_sel         (wr_sel),
    .wr_data        (wr_data),
    .wr_err         (wr_err),
    .commit_req     (commit_req),
    .commit_pending (commit_pending),
    .commit_ack     (commit_ack),
    .ch_out         (ch_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic sel, input int data, input logic exp_err, input string tag);
    wr_en   = 1'b1;
    wr_addr = 2'(ch);
    wr_sel  = sel;
    wr_data = AW'(data);
    tick();
    wr_en = 1'b0;
    chk(tag, 64'(wr_err), 64'(exp_err));
  endtask

  // Commit while stopped: ack expected on the second edge after the request.
  task automatic commit_stopped(input string tag);
    int k;
    hwag_start = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    k = -1;
    for (int j = 0; j < 8; j++) begin
      if (commit_ack) begin
        k = j;
        break;
      end
      tick();
    end
    chk(tag, 64'(k), 64'd1);
  endtask

  task automatic sweep(input int a0, input int n);
    logic [CH-1:0] prev;
    int a;
    for (int c = 0; c < CH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; high_cnt[c] = 0;
      rise_ang[c] = -1; fall_ang[c] = -1;
    end
    ack_cnt = 0; ack_ang = -1; err_cnt = 0;
    prev = ch_out;
    hwag_start = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = (a0 + i) % (TOP + 1);
      angle = AW'(a);
      tick();
      for (int c = 0; c < CH; c++) begin
        if (ch_out[c] && !prev[c]) begin rise_cnt[c]++; rise_ang[c] = a; end
        if (!ch_out[c] && prev[c]) begin fall_cnt[c]++; fall_ang[c] = a; end
        if (ch_out[c]) high_cnt[c]++;
      end
      if (commit_ack) begin ack_cnt++; ack_ang = a; end
      if (wr_err) err_cnt++;
      prev = ch_out;
    end
  endtask

  initial begin
    rst = 1'b1; hwag_start = 1'b0; angle = '0;
    wr_en = 1'b0; wr_addr = '0; wr_sel = 1'b0; wr_data = '0; commit_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ch_out", 64'(ch_out), 64'd0);
    chk("rst_pending", 64'(commit_pending), 64'd0);
    chk("rst_ack", 64'(commit_ack), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);

    // Reset-state registers never turn any channel on.
    sweep(0, TOP + 1);
    chk("idle_rises", 64'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 64'd0);
    chk("idle_wr_err", 64'(err_cnt), 64'd0);

    // ch0 1152..1216 committed while stopped.
    hwag_start = 1'b0;
    wr(0, 1'b0, 1152, 1'b0, "wr0_set_err");
    wr(0, 1'b1, 1216, 1'b0, "wr0_rst_err");
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("c0_pend_1", 64'(commit_pending), 64'd1);
    chk("c0_ack_1", 64'(commit_ack), 64'd0);
    tick();
    chk("c0_ack_2", 64'(commit_ack), 64'd1);
    chk("c0_pend_2", 64'(commit_pending), 64'd0);
    tick();
    chk("c0_ack_3", 64'(commit_ack), 64'd0);
    sweep(0, TOP + 1);
    chk("ch0_rise_ang", 64'(rise_ang[0]), 64'd1152);
    chk("ch0_fall_ang", 64'(fall_ang[0]), 64'd1216);
    chk("ch0_rise_cnt", 64'(rise_cnt[0]), 64'd1);
    chk("ch0_high_cnt", 64'(high_cnt[0]), 64'd64);

    // ch1 committed while running: waits for the wrap.
    hwag_start = 1'b1;
    angle = AW'(3000);
    tick();
    wr(1, 1'b0, 3072, 1'b0, "wr1_set_err");
    wr(1, 1'b1, 3136, 1'b0, "wr1_rst_err");
    commit_req = 1'b1;
    tick();
    chk("c1_pend", 64'(commit_pending), 64'd1);
    tick();
    commit_req = 1'b0;
    sweep(3001, TOP - 3000);
    chk("c1_no_ack", 64'(ack_cnt), 64'd0);
    chk("c1_pend_hold", 64'(commit_pending), 64'd1);
    chk("c1_no_rise", 64'(rise_cnt[1]), 64'd0);
    sweep(0, TOP + 1);
    chk("c1_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("c1_ack_ang", 64'(ack_ang), 64'd0);
    chk("c1_pend_clr", 64'(commit_pending), 64'd0);
    chk("ch1_rise_ang", 64'(rise_ang[1]), 64'd3072);
    chk("ch1_fall_ang", 64'(fall_ang[1]), 64'd3136);
    chk("ch1_high_cnt", 64'(high_cnt[1]), 64'd64);

    // ch2 dwell spanning the wrap.
    wr(2, 1'b0, 7616, 1'b0, "wr2_set_err");
    wr(2, 1'b1, 64, 1'b0, "wr2_rst_err");
    commit_stopped("c2_latency");
    sweep(7000, 1000);
    chk("ch2_rise_ang", 64'(rise_ang[2]), 64'd7616);
    chk("ch2_fall_ang", 64'(fall_ang[2]), 64'd64);
    chk("ch2_high_cnt", 64'(high_cnt[2]), 64'd128);

    // Boundary write accepted, out-of-range write rejected and ignored.
    wr(3, 1'b0, 2000, 1'b0, "wr3_set_err");
    wr(3, 1'b1, TOP, 1'b0, "wr3_top_err");
    wr(3, 1'b0, TOP + 1, 1'b1, "wr3_bad_err");
    tick();
    chk("wr3_err_clr", 64'(wr_err), 64'd0);
    commit_stopped("c3_latency");
    sweep(0, TOP + 1);
    chk("ch3_rise_ang", 64'(rise_ang[3]), 64'd2000);
    chk("ch3_fall_ang", 64'(fall_ang[3]), 64'd7679);
    chk("ch3_high_cnt", 64'(high_cnt[3]), 64'd5679);

    // Generator stop and async reset mid-dwell.
    hwag_start = 1'b1;
    angle = AW'(1152); tick();
    angle = AW'(1180); tick();
    chk("stop_on", 64'(ch_out[0]), 64'd1);
    hwag_start = 1'b0;
    tick();
    chk("stop_off", 64'(ch_out[0]), 64'd0);
    hwag_start = 1'b1;
    angle = AW'(1152); tick();
    angle = AW'(1180);
    commit_req = 1'b1; tick();
    commit_req = 1'b0;
    chk("arst_pre_on", 64'(ch_out[0]), 64'd1);
    chk("arst_pre_pend", 64'(commit_pending), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ch_out", 64'(ch_out), 64'd0);
    chk("arst_pending", 64'(commit_pending), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    sweep(1100, 200);
    chk("arst_act_clr", 64'(rise_cnt[0]), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
